// File: rtl/keypad_reader.sv
// rtl/keypad_reader.sv - 4x4 keypad scanner and debouncer feeding a key-code FIFO
// Optional auto-repeat of a held key is built when KEYPAD_REPEAT_EN is defined.

module keypad_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 4
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         valid_o,
  output logic         overflow_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          full, pop_ok, push_ok;

  always_comb begin
    full    = count_q == FULL_CNT;
    pop_ok  = pop_i && (count_q != '0);
    // A simultaneous pop frees the slot a full FIFO needs for the push.
    push_ok = push_i && (!full || pop_ok);
    wr_d    = push_ok ? wr_q + 1'b1 : wr_q;
    rd_d    = pop_ok ? rd_q + 1'b1 : rd_q;
    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + 1'b1;
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - 1'b1;
    end
    ovf_d   = ovf_q || (push_i && !push_ok);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_q] <= push_data_i;
    end
  end

  assign valid_o    = count_q != '0;
  assign data_o     = valid_o ? mem_q[rd_q] : '0;
  assign overflow_o = ovf_q;
endmodule

module keypad_reader #(
  parameter int SCAN_DIV       = 200,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int FIFO_DEPTH     = 8
`ifdef KEYPAD_REPEAT_EN
  , parameter int REPEAT_SCANS = 32
`endif
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [3:0] row_i,
  output logic [3:0] col_o,
  input  logic       rden_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       overflow_o
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_DONE   = CW'(DEBOUNCE_SCANS);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_SCANS + 1);
  localparam logic [RW-1:0] REP_DONE = RW'(REPEAT_SCANS);
`endif

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_t;

  logic [3:0]    sync1_q, sync2_q;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [1:0]    col_q, col_d;
  logic [15:0]   hits_q, hits_d;
  logic [3:0]    row_hit, col_onehot;
  logic [15:0]   col_hits, frame_keys;
  logic          sample, frame_end;
  logic [4:0]    key_cnt;
  logic [3:0]    key_code;
  logic          is_none, is_single;

  state_t        state_q, state_d;
  logic [3:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          push;
  logic [3:0]    push_code;
  logic [3:0]    fifo_code;
`ifdef KEYPAD_REPEAT_EN
  logic [RW-1:0] rep_q, rep_d, rep_inc;
`endif

  always_comb begin
    row_hit    = ~sync2_q;
    col_onehot = 4'b0001 << col_q;
    // Bit 4*r+c of the frame vector is the key at row r, column c.
    col_hits   = {row_hit[3] ? col_onehot : 4'h0,
                  row_hit[2] ? col_onehot : 4'h0,
                  row_hit[1] ? col_onehot : 4'h0,
                  row_hit[0] ? col_onehot : 4'h0};
    sample     = dwell_q == DWELL_LAST;
    frame_end  = sample && (col_q == 2'd3);
    frame_keys = hits_q | col_hits;
    dwell_d    = sample ? '0 : dwell_q + 1'b1;
    col_d      = sample ? col_q + 2'd1 : col_q;
    hits_d     = frame_end ? '0 : (sample ? frame_keys : hits_q);
    key_cnt    = '0;
    key_code   = '0;
    for (int i = 0; i < 16; i++) begin
      if (frame_keys[i[3:0]]) begin
        key_cnt  = key_cnt + 5'd1;
        key_code = i[3:0];
      end
    end
    is_none   = key_cnt == 5'd0;
    is_single = key_cnt == 5'd1;
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    cnt_inc = cnt_q + 1'b1;
`ifdef KEYPAD_REPEAT_EN
    rep_d   = rep_q;
    rep_inc = rep_q + 1'b1;
`endif
    if (frame_end) begin
      case (state_q)
        IDLE: begin
          if (is_single) begin
            cand_d = key_code;
            cnt_d  = CNT_ONE;
            if (CNT_ONE == CNT_DONE) begin
              push    = 1'b1;
              state_d = HELD;
            end else begin
              state_d = DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (!is_single) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (key_code == cand_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_DONE) begin
              push    = 1'b1;
              state_d = HELD;
            end
          end else begin
            cand_d = key_code;
            cnt_d  = CNT_ONE;
          end
        end
        HELD: begin
          if (is_none) begin
            if (CNT_ONE == CNT_DONE) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              state_d = RELEASE;
              cnt_d   = CNT_ONE;
            end
          end
`ifdef KEYPAD_REPEAT_EN
          if (is_single && key_code == cand_q) begin
            if (rep_inc == REP_DONE) begin
              push  = 1'b1;
              rep_d = '0;
            end else begin
              rep_d = rep_inc;
            end
          end else begin
            rep_d = '0;
          end
`endif
        end
        RELEASE: begin
          if (!is_none) begin
            state_d = HELD;
            cnt_d   = '0;
          end else if (cnt_inc == CNT_DONE) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: state_d = IDLE;
      endcase
    end
`ifdef KEYPAD_REPEAT_EN
    if (state_d == HELD && state_q != HELD) begin
      rep_d = '0;
    end
`endif
    push_code = cand_d;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
      dwell_q <= '0;
      col_q   <= '0;
      hits_q  <= '0;
      state_q <= IDLE;
      cand_q  <= '0;
      cnt_q   <= '0;
`ifdef KEYPAD_REPEAT_EN
      rep_q   <= '0;
`endif
    end else begin
      sync1_q <= row_i;
      sync2_q <= sync1_q;
      dwell_q <= dwell_d;
      col_q   <= col_d;
      hits_q  <= hits_d;
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
`ifdef KEYPAD_REPEAT_EN
      rep_q   <= rep_d;
`endif
    end
  end

  keypad_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (4)
  ) u_fifo (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .push_i      (push),
    .push_data_i (push_code),
    .pop_i       (rden_i),
    .data_o      (fifo_code),
    .valid_o     (valid_o),
    .overflow_o  (overflow_o)
  );

  assign col_o  = ~col_onehot;
  assign data_o = {4'h0, fifo_code};
endmodule

// File: tb/tb_keypad_reader.sv
// tb/tb_keypad_reader.sv - randomized self-checking bench for keypad_reader
// Reference model: per-frame key sets, acceptance by run lengths, FIFO as a queue.

module tb_keypad_reader;
  localparam int SD    = 4;
  localparam int DB    = 2;
  localparam int DEPTH = 4;
  localparam int FRAME = 4 * SD;

  logic       clk_i   = 1'b0;
  logic       reset_i = 1'b1;
  logic [3:0] row_i;
  logic [3:0] col_o;
  logic       rden_i  = 1'b0;
  logic [7:0] data_o;
  logic       valid_o;
  logic       overflow_o;

  logic [15:0] keys = 16'h0;
  int n_checks = 0;
  int n_pass   = 0;

  logic [3:0] exp_q[$];
  bit m_ovf;
  bit m_held;
  int m_cand, m_run, m_quiet;

  keypad_reader #(
    .SCAN_DIV       (SD),
    .DEBOUNCE_SCANS (DB),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .row_i      (row_i),
    .col_o      (col_o),
    .rden_i     (rden_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .overflow_o (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  // Ideal matrix: a row reads low when a pressed key in it sits on a driven column.
  always_comb begin
    row_i[0] = ~|(keys[3:0]   & ~col_o);
    row_i[1] = ~|(keys[7:4]   & ~col_o);
    row_i[2] = ~|(keys[11:8]  & ~col_o);
    row_i[3] = ~|(keys[15:12] & ~col_o);
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [15:0] key(input int k);
    key = 16'h0001 << k;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_ovf   = 1'b0;
    m_held  = 1'b0;
    m_cand  = -1;
    m_run   = 0;
    m_quiet = 0;
  endtask

  task automatic model_push(input int k);
    if (exp_q.size() == DEPTH) m_ovf = 1'b1;
    else exp_q.push_back(4'(k));
  endtask

  task automatic model_frame(input logic [15:0] m);
    int n;
    int k;
    n = $countones(m);
    k = -1;
    for (int i = 0; i < 16; i++) if (m[i[3:0]]) k = i;
    if (!m_held) begin
      if (n == 1) begin
        if (k == m_cand) m_run++;
        else begin
          m_cand = k;
          m_run  = 1;
        end
        if (m_run == DB) begin
          model_push(k);
          m_held  = 1'b1;
          m_quiet = 0;
        end
      end else begin
        m_cand = -1;
        m_run  = 0;
      end
    end else if (n == 0) begin
      m_quiet++;
      if (m_quiet == DB) begin
        m_held = 1'b0;
        m_cand = -1;
        m_run  = 0;
      end
    end else begin
      m_quiet = 0;
    end
  endtask

  task automatic check_outputs();
    logic [7:0] exp_data;
    exp_data = (exp_q.size() > 0) ? {4'h0, exp_q[0]} : 8'h00;
    check("valid", {7'h0, valid_o}, {7'h0, exp_q.size() > 0});
    check("data", data_o, exp_data);
    check("overflow", {7'h0, overflow_o}, {7'h0, m_ovf});
  endtask

  task automatic run_frame(input logic [15:0] m, input int npop);
    logic [3:0] exp_col;
    keys = m;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk_i);
      exp_col = ~(4'b0001 << (i / SD));
      check("col", {4'h0, col_o}, {4'h0, exp_col});
      check_outputs();
      if (i >= 2 && i < 2 + npop) begin
        rden_i = 1'b1;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end else begin
        rden_i = 1'b0;
      end
      @(posedge clk_i);
    end
    #1;
    model_frame(m);
  endtask

  task automatic apply_reset();
    @(posedge clk_i);
    #1 reset_i = 1'b1;
    rden_i = 1'b0;
    #1;
    check("rst_col", {4'h0, col_o}, 8'h0E);
    check("rst_valid", {7'h0, valid_o}, 8'h00);
    check("rst_ovf", {7'h0, overflow_o}, 8'h00);
    check("rst_data", data_o, 8'h00);
    model_reset();
    @(posedge clk_i);
    @(posedge clk_i);
    #1 reset_i = 1'b0;
  endtask

  task automatic press(input int k);
    run_frame(key(k), 0);
    run_frame(key(k), 0);
    run_frame(16'h0, 0);
    run_frame(16'h0, 0);
  endtask

  initial begin
    int last;
    int r;
    int a;
    int b;
    logic [15:0] m;
    model_reset();
    apply_reset();
    repeat (3) run_frame(16'h0, 0);

    run_frame(key(9), 0);
    run_frame(key(9), 0);
    check("key9_data", data_o, 8'h09);
    check("key9_valid", {7'h0, valid_o}, 8'h01);
    run_frame(key(9), 1);
    check("key9_popped", {7'h0, valid_o}, 8'h00);
    run_frame(16'h0, 0);
    run_frame(16'h0, 0);

    run_frame(key(5), 0);
    run_frame(16'h0, 0);
    run_frame(key(5), 0);
    check("bounce_rejected", {7'h0, valid_o}, 8'h00);
    run_frame(key(5), 0);
    check("key5_data", data_o, 8'h05);
    run_frame(16'h0, 1);
    run_frame(16'h0, 0);

    repeat (3) run_frame(key(0) | key(15), 0);
    check("multi_no_push", {7'h0, valid_o}, 8'h00);
    run_frame(16'h0, 0);
    run_frame(key(15), 0);
    run_frame(key(15), 0);
    check("keyf_data", data_o, 8'h0F);
    run_frame(16'h0, 1);
    run_frame(16'h0, 0);

    press(1);
    press(2);
    press(3);
    press(4);
    press(6);
    check("ovf_set", {7'h0, overflow_o}, 8'h01);
    check("full_head", data_o, 8'h01);
    run_frame(16'h0, 4);
    check("drained", {7'h0, valid_o}, 8'h00);

    press(7);
    press(8);
    run_frame(key(12), 0);
    repeat (5) @(posedge clk_i);
    apply_reset();
    run_frame(key(12), 0);
    check("rst_fresh_debounce", {7'h0, valid_o}, 8'h00);
    run_frame(key(12), 0);
    check("rst_keyc_data", data_o, 8'h0C);

    last = 3;
    for (int f = 0; f < 80; f++) begin
      r = $urandom_range(0, 9);
      if (r < 3) begin
        m = 16'h0;
      end else if (r < 8) begin
        m = key(last);
      end else if (r < 9) begin
        last = $urandom_range(0, 15);
        m = key(last);
      end else begin
        a = $urandom_range(0, 15);
        b = (a + $urandom_range(1, 15)) % 16;
        m = key(a) | key(b);
      end
      run_frame(m, $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/keypad_reader.md
Name: keypad_reader

Overview:
- Input-side counterpart of the 7-segment display path. Scans a 4x4 active-low matrix keypad and debounces key presses.
- Each accepted press is encoded as a hex key code and pushed into an internal FIFO.
- The CPU pops codes from the FIFO with a read-enable strobe.
- Sits on the CPU I/O bus beside the display block.

Parameters:
- SCAN_DIV, 200: clock cycles each column is driven. Legal range is at least 4.
- DEBOUNCE_SCANS, 4: consecutive identical full scan frames needed to accept a press, and consecutive empty frames needed to accept a release. Legal range is at least 1.
- FIFO_DEPTH, 8: FIFO entries. Must be a power of 2, at least 2.
- REPEAT_SCANS, 32: frames between auto-repeat pushes. Used only with KEYPAD_REPEAT_EN.

Ports:
- clk_i  input  1  system clock; everything is on the rising edge.
- reset_i  input  1  asynchronous, active-high reset.
- row_i  input  4  keypad rows. Active-low, externally pulled up, asynchronous to clk_i.
- col_o  output  4  keypad column drive. Active-low, one-hot-low.
- rden_i  input  1  CPU pop strobe.
- data_o  output  8  FIFO head, {4'h0, key code}.
- valid_o  output  1  FIFO not empty.
- overflow_o  output  1  sticky flag: a press was dropped because the FIFO was full.

Behaviour:
- Reset (asynchronous, immediate, including mid-scan or mid-debounce):
  - col_o=4'b1110; data_o=8'h00; valid_o=0; overflow_o=0.
  - FIFO emptied; FSM to IDLE; all counters 0.
- Synchroniser: row_i passes through a 2-flop synchroniser before any use.
- Scanner:
  - A dwell counter runs 0..SCAN_DIV-1.
  - Column c (0..3) is driven low, with col_o bit c=0, for one dwell.
  - The synchronised rows are sampled on the dwell cycle SCAN_DIV-1, then the column advances, wrapping 3->0.
  - A frame is 4 dwells, i.e. 4*SCAN_DIV cycles. The frame ends on column 3's sample cycle.
- Key code: row r, column c -> code = 4*r + c (0x0..0xF).
- Frame result, evaluated at frame end:
  - NONE: no key seen.
  - SINGLE(code): exactly one key seen.
  - MULTI: two or more keys seen. MULTI is treated like NONE for acceptance, but never pushes.
- FSM states: IDLE, DEBOUNCE, HELD, RELEASE. It updates only at frame end.
- IDLE:
  - SINGLE(k): latch candidate=k, cnt=1, go to DEBOUNCE.
  - If DEBOUNCE_SCANS==1, push k immediately and go to HELD.
- DEBOUNCE:
  - SINGLE(candidate): cnt++. When cnt reaches DEBOUNCE_SCANS, push candidate and go to HELD.
  - SINGLE(other key j): candidate=j, cnt=1.
  - NONE or MULTI: go to IDLE.
- HELD:
  - NONE: cnt=1, go to RELEASE. If DEBOUNCE_SCANS==1, go straight to IDLE.
  - SINGLE (any key) or MULTI: stay in HELD, no push.
- RELEASE:
  - NONE: cnt++. When cnt reaches DEBOUNCE_SCANS, go to IDLE.
  - Any key seen: go to HELD.
- Exactly one push per accepted press. The push is issued on the frame-end cycle; valid_o and data_o update the following cycle.
- FIFO, first-word-fall-through:
  - data_o shows the head while valid_o=1, and 8'h00 when empty.
  - rden_i with valid_o=1 pops; the new head or empty status is visible the next cycle.
  - rden_i while empty is ignored.
  - Push while full, without a simultaneous pop: the new code is dropped and overflow_o is set. overflow_o clears only on reset.
  - Push and pop in the same cycle while full: both occur and no overflow is flagged.
  - Push and pop in the same cycle while empty: the push occurs and the pop is ignored.
  - Pointers are log2(FIFO_DEPTH) bits wide and wrap naturally. An occupancy counter of log2(FIFO_DEPTH)+1 bits distinguishes full from empty.

Optional Feature:
- Macro: KEYPAD_REPEAT_EN.
- When defined, HELD carries a repeat counter:
  - The counter clears on entry to HELD.
  - It increments on every HELD frame whose result is SINGLE(the accepted key).
  - When it reaches REPEAT_SCANS, the accepted key is pushed again and the counter clears.
  - Any other frame result clears the counter.
- When not defined: no repeat logic exists, and each press pushes exactly once.

Test Plan (bench overrides: SCAN_DIV=4, DEBOUNCE_SCANS=2, FIFO_DEPTH=4):
- Reset, then 3 frames with no key:
  - col_o cycles 1110, 1101, 1011, 0111, each for 4 cycles.
  - valid_o=0, data_o=8'h00, overflow_o=0.
- Hold row 2, column 1 low for 2 full frames:
  - Exactly one push.
  - data_o=8'h09 and valid_o=1 the cycle after the second frame end.
  - Pulse rden_i -> valid_o=0 on the next cycle.
- Key 0x5 held for 1 frame, then released for 1 frame, then key 0x5 held for 2 frames:
  - Only one code (0x05) is pushed, after the second hold.
  - The first, 1-frame bounce is rejected.
- Keys 0x0 and 0xF held together for 3 frames -> no push. Then release, then hold 0xF for 2 frames -> one push of 8'h0F.
- Five distinct debounced presses (0x1, 0x2, 0x3, 0x4, 0x6) with no reads:
  - FIFO holds 01, 02, 03, 04.
  - overflow_o=1 after the fifth press.
  - Four pops return 01, 02, 03, 04 in order, then valid_o=0.
- Assert reset_i mid-DEBOUNCE with 2 entries queued:
  - Immediately: valid_o=0, overflow_o=0, col_o=1110.
  - After release of reset, the key still held needs 2 fresh frames before it is pushed.
  - With KEYPAD_REPEAT_EN and REPEAT_SCANS=3, holding 0xA pushes 0x0A every 3 frames after the initial accept.
